// File: rtl/tri_edge_scheduler_pkg.sv
// Shared types for the triangle edge scheduler: FSM encoding, edge record, screen limits.
// Edge record widths match the scheduler's default vertex widths.
package tri_edge_scheduler_pkg;

    localparam int SCREEN_W = 320;
    localparam int SCREEN_H = 200;
    localparam int EDGE_XW  = 9;
    localparam int EDGE_YW  = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SORT,
        ST_ISSUE,
        ST_WAIT,
        ST_CMPL
    } state_t;

    typedef struct packed {
        logic [EDGE_XW-1:0] x1;
        logic [EDGE_XW-1:0] x2;
        logic [EDGE_YW-1:0] y1;
        logic [EDGE_YW-1:0] y2;
        logic               is_long;
    } edge_t;

    function automatic edge_t mk_edge(
        input logic [EDGE_XW-1:0] x1,
        input logic [EDGE_XW-1:0] x2,
        input logic [EDGE_YW-1:0] y1,
        input logic [EDGE_YW-1:0] y2,
        input logic               is_long
    );
        edge_t e;
        e.x1      = x1;
        e.x2      = x2;
        e.y1      = y1;
        e.y2      = y2;
        e.is_long = is_long;
        return e;
    endfunction

endpackage

// File: rtl/tri_vtx_sort.sv
// Stable 3-vertex sort by Y (s0 = min); purely combinational, no backpressure.
module tri_vtx_sort #(
    parameter int XW = 9,
    parameter int YW = 8
) (
    input  logic [3*XW-1:0] in_x,
    input  logic [3*YW-1:0] in_y,
    output logic [3*XW-1:0] s_x,
    output logic [3*YW-1:0] s_y
);

    logic [XW-1:0] x [3];
    logic [YW-1:0] y [3];
    logic [XW-1:0] tx;
    logic [YW-1:0] ty;

    // Swapping only on strictly greater Y keeps equal-Y vertices in input order.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            x[i] = in_x[i*XW +: XW];
            y[i] = in_y[i*YW +: YW];
        end
        tx = '0;
        ty = '0;
        if (y[0] > y[1]) begin
            tx = x[0]; x[0] = x[1]; x[1] = tx;
            ty = y[0]; y[0] = y[1]; y[1] = ty;
        end
        if (y[1] > y[2]) begin
            tx = x[1]; x[1] = x[2]; x[2] = tx;
            ty = y[1]; y[1] = y[2]; y[2] = ty;
        end
        if (y[0] > y[1]) begin
            tx = x[0]; x[0] = x[1]; x[1] = tx;
            ty = y[0]; y[0] = y[1]; y[1] = ty;
        end
        s_x = {x[2], x[1], x[0]};
        s_y = {y[2], y[1], y[0]};
    end

endmodule

// File: rtl/tri_edge_scheduler.sv
// Round-robin triangle intake, Y-sort and one-at-a-time edge issue to the edge-walker (SCAN_CLIP_EN adds Y clipping).
// Accept->ew_start 2 cycles, ew_done->next ew_start 2 cycles; requesters wait on req_ready while busy.
module tri_edge_scheduler
    import tri_edge_scheduler_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int XW       = 9,
    parameter int YW       = 8,
    parameter int IDW      = 4,
    parameter int SCREEN_H = tri_edge_scheduler_pkg::SCREEN_H
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*3*XW-1:0] req_x,
    input  logic [NUM_REQ*3*YW-1:0] req_y,
    input  logic [NUM_REQ*IDW-1:0]  req_id,
    output logic                    ew_start,
    output logic [XW-1:0]           ew_x1,
    output logic [XW-1:0]           ew_x2,
    output logic [YW-1:0]           ew_y1,
    output logic [YW-1:0]           ew_y2,
    output logic                    ew_long,
    input  logic                    ew_done,
    output logic                    cmp_valid,
    output logic [IDW-1:0]          cmp_id,
    output logic [1:0]              cmp_edges,
    output logic                    busy
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
`ifdef SCAN_CLIP_EN
    localparam logic [EDGE_YW-1:0] CLIP_H = EDGE_YW'(SCREEN_H);
`endif

    state_t          state, nxt;
    logic [PW-1:0]   ptr, gnt_idx;
    logic            gnt_any;
    int              c;
    logic [3*XW-1:0] vx, sx;
    logic [3*YW-1:0] vy, sy;
    logic [IDW-1:0]  id_q;
    edge_t           cand [3];
    logic            cvld [3];
    edge_t           list_c [3];
    logic [1:0]      n_c;
    edge_t           edge_q [3];
    logic [1:0]      n_q, eidx;
    edge_t           ew_q;
    logic            done_q;

    tri_vtx_sort #(.XW(XW), .YW(YW)) u_sort (
        .in_x (vx),
        .in_y (vy),
        .s_x  (sx),
        .s_y  (sy)
    );

    // Descending scan so the lowest offset from the pointer wins.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        c       = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            c = int'(ptr) + k;
            if (c >= NUM_REQ) c = c - NUM_REQ;
            if (req_valid[c]) begin
                gnt_any = 1'b1;
                gnt_idx = PW'(c);
            end
        end
    end

    always_comb begin
        cand[0] = mk_edge(EDGE_XW'(sx[0 +: XW]), EDGE_XW'(sx[2*XW +: XW]),
                          EDGE_YW'(sy[0 +: YW]), EDGE_YW'(sy[2*YW +: YW]), 1'b1);
        cand[1] = mk_edge(EDGE_XW'(sx[0 +: XW]), EDGE_XW'(sx[XW +: XW]),
                          EDGE_YW'(sy[0 +: YW]), EDGE_YW'(sy[YW +: YW]), 1'b0);
        cand[2] = mk_edge(EDGE_XW'(sx[XW +: XW]), EDGE_XW'(sx[2*XW +: XW]),
                          EDGE_YW'(sy[YW +: YW]), EDGE_YW'(sy[2*YW +: YW]), 1'b0);
        for (int k = 0; k < 3; k++) begin
`ifdef SCAN_CLIP_EN
            if (cand[k].y2 >= CLIP_H) begin
                cand[k].y2 = CLIP_H - 1'b1;
                cand[k].x2 = cand[k].x1;
            end
            cvld[k] = (cand[k].y1 < CLIP_H) && (cand[k].y1 < cand[k].y2);
`else
            cvld[k] = cand[k].y1 < cand[k].y2;
`endif
        end
        n_c    = '0;
        list_c = '{default: '0};
        for (int k = 0; k < 3; k++) begin
            if (cvld[k]) begin
                list_c[n_c] = cand[k];
                n_c         = n_c + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= ST_IDLE;
        else      state <= nxt;
    end

    always_comb begin
        nxt       = state;
        req_ready = '0;
        ew_start  = 1'b0;
        cmp_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                if (gnt_any) begin
                    req_ready[gnt_idx] = 1'b1;
                    nxt                = ST_SORT;
                end
            end
            ST_SORT:  nxt = (n_c == 2'd0) ? ST_CMPL : ST_ISSUE;
            ST_ISSUE: begin
                ew_start = 1'b1;
                nxt      = ST_WAIT;
            end
            ST_WAIT: begin
                if (done_q) nxt = ((eidx + 2'd1) < n_q) ? ST_ISSUE : ST_CMPL;
            end
            ST_CMPL: begin
                cmp_valid = 1'b1;
                nxt       = ST_IDLE;
            end
            default: nxt = ST_IDLE;
        endcase
    end

    // ew_done is registered so every hop through WAIT costs the same two cycles.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr    <= '0;
            vx     <= '0;
            vy     <= '0;
            id_q   <= '0;
            edge_q <= '{default: '0};
            n_q    <= '0;
            eidx   <= '0;
            ew_q   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= ew_done && (state == ST_WAIT);
            case (state)
                ST_IDLE: begin
                    if (gnt_any) begin
                        vx   <= req_x[int'(gnt_idx)*3*XW +: 3*XW];
                        vy   <= req_y[int'(gnt_idx)*3*YW +: 3*YW];
                        id_q <= req_id[int'(gnt_idx)*IDW +: IDW];
                        ptr  <= (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
                    end
                end
                ST_SORT: begin
                    edge_q <= list_c;
                    n_q    <= n_c;
                    eidx   <= '0;
                    if (n_c != 2'd0) ew_q <= list_c[0];
                end
                ST_WAIT: begin
                    if (done_q && ((eidx + 2'd1) < n_q)) begin
                        eidx <= eidx + 2'd1;
                        ew_q <= edge_q[eidx + 2'd1];
                    end
                end
                default: ;
            endcase
        end
    end

    assign ew_x1     = XW'(ew_q.x1);
    assign ew_x2     = XW'(ew_q.x2);
    assign ew_y1     = YW'(ew_q.y1);
    assign ew_y2     = YW'(ew_q.y2);
    assign ew_long   = ew_q.is_long;
    assign cmp_id    = id_q;
    assign cmp_edges = n_q;
    assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_tri_edge_scheduler.sv
// Directed and randomized bench for tri_edge_scheduler against a vertex-ranking edge model.
module tb_tri_edge_scheduler;

    localparam int NUM_REQ = 2;
    localparam int XW      = 9;
    localparam int YW      = 8;
    localparam int IDW     = 4;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ-1:0]      req_ready;
    logic [NUM_REQ*3*XW-1:0] req_x;
    logic [NUM_REQ*3*YW-1:0] req_y;
    logic [NUM_REQ*IDW-1:0]  req_id;
    logic                    ew_start;
    logic [XW-1:0]           ew_x1, ew_x2;
    logic [YW-1:0]           ew_y1, ew_y2;
    logic                    ew_long;
    logic                    ew_done;
    logic                    cmp_valid;
    logic [IDW-1:0]          cmp_id;
    logic [1:0]              cmp_edges;
    logic                    busy;

    tri_edge_scheduler #(
        .NUM_REQ(NUM_REQ), .XW(XW), .YW(YW), .IDW(IDW), .SCREEN_H(200)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .req_id(req_id),
        .ew_start(ew_start), .ew_x1(ew_x1), .ew_x2(ew_x2),
        .ew_y1(ew_y1), .ew_y2(ew_y2), .ew_long(ew_long),
        .ew_done(ew_done),
        .cmp_valid(cmp_valid), .cmp_id(cmp_id), .cmp_edges(cmp_edges),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int x1;
        int x2;
        int y1;
        int y2;
        int lng;
    } medge_t;

    medge_t exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Rank each vertex (ties broken by input position), then walk long/upper/lower.
    function automatic void build_expect(input int xs[3], input int ys[3]);
        int ord[3];
        int tix[3] = '{0, 0, 1};
        int bix[3] = '{2, 1, 2};
        int rank, a, b, x1, x2, y1, y2;
        medge_t e;
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            rank = 0;
            for (int j = 0; j < 3; j++)
                if (ys[j] < ys[i] || (ys[j] == ys[i] && j < i)) rank++;
            ord[rank] = i;
        end
        for (int p = 0; p < 3; p++) begin
            a  = ord[tix[p]];
            b  = ord[bix[p]];
            x1 = xs[a]; x2 = xs[b];
            y1 = ys[a]; y2 = ys[b];
`ifdef SCAN_CLIP_EN
            if (y1 >= 200) continue;
            if (y2 >= 200) begin
                y2 = 199;
                x2 = x1;
            end
`endif
            if (y1 < y2) begin
                e = '{x1, x2, y1, y2, (p == 0) ? 1 : 0};
                exp_q.push_back(e);
            end
        end
    endfunction

    task automatic load(input int r, input int xs[3], input int ys[3], input int id);
        req_x[r*3*XW +: 3*XW] = {XW'(xs[2]), XW'(xs[1]), XW'(xs[0])};
        req_y[r*3*YW +: 3*YW] = {YW'(ys[2]), YW'(ys[1]), YW'(ys[0])};
        req_id[r*IDW +: IDW]  = IDW'(id);
    endtask

    // Offers a triangle on requester r, plays the walker with a fixed ack delay, checks everything.
    task automatic run_tri(input int r, input int xs[3], input int ys[3], input int id,
                           input int dly, input bit keep);
        int k;
        int n;
        build_expect(xs, ys);
        n = exp_q.size();
        load(r, xs, ys, id);
        req_valid[r] = 1'b1;
        #1;
        k = 0;
        while (req_ready == '0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("grant", 32'(req_ready), 32'(1 << r));
        for (int e = 0; e <= n; e++) begin
            k = 0;
            do begin
                @(negedge clk);
                k++;
                ew_done = 1'b0;
                if (!keep) req_valid[r] = 1'b0;
            end while (!ew_start && !cmp_valid && k < 40);
            check("latency", k, 2);
            check("no_ready_busy", 32'(req_ready), 0);
            check("busy", busy, 1);
            if (e < n) begin
                check("ew_start", ew_start, 1);
                check("ew_x1", ew_x1, exp_q[e].x1);
                check("ew_x2", ew_x2, exp_q[e].x2);
                check("ew_y1", ew_y1, exp_q[e].y1);
                check("ew_y2", ew_y2, exp_q[e].y2);
                check("ew_long", ew_long, exp_q[e].lng);
                repeat (dly) @(negedge clk);
                ew_done = 1'b1;
            end else begin
                check("cmp_valid", cmp_valid, 1);
                check("no_extra_edge", ew_start, 0);
                check("cmp_id", cmp_id, id);
                check("cmp_edges", cmp_edges, n);
            end
        end
        @(negedge clk);
        check("cmp_pulse", cmp_valid, 0);
    endtask

    initial begin
        #500000;
        $error("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  xs[3];
        int  ys[3];
        int  k;
        bit  seen;

        rst       = 1'b0;
        req_valid = '0;
        req_x     = '0;
        req_y     = '0;
        req_id    = '0;
        ew_done   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_ready", 32'(req_ready), 0);
        check("rst_start", ew_start, 0);
        check("rst_cmp", cmp_valid, 0);
        check("rst_x1", ew_x1, 0);
        check("rst_y2", ew_y2, 0);
        check("rst_edges", cmp_edges, 0);
        rst = 1'b1;
        @(negedge clk);

        // General triangle, flat-top, fully degenerate.
        xs = '{10, 100, 40}; ys = '{0, 50, 120};
        run_tri(0, xs, ys, 3, 3, 1'b0);
        xs = '{0, 80, 40};   ys = '{20, 20, 90};
        run_tri(1, xs, ys, 5, 3, 1'b0);
        xs = '{5, 60, 9};    ys = '{30, 30, 30};
        run_tri(0, xs, ys, 7, 3, 1'b0);

        // Fairness from a fresh pointer with both requesters always valid.
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        xs = '{10, 100, 40}; ys = '{0, 50, 120};
        load(0, xs, ys, 1);
        xs = '{0, 80, 40};   ys = '{20, 20, 90};
        load(1, xs, ys, 2);
        req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) begin
                xs = '{10, 100, 40}; ys = '{0, 50, 120};
                run_tri(0, xs, ys, 1, 2, 1'b1);
            end else begin
                xs = '{0, 80, 40};   ys = '{20, 20, 90};
                run_tri(1, xs, ys, 2, 2, 1'b1);
            end
        end
        req_valid = '0;
        @(negedge clk);

        // Reset while waiting on the first edge.
        xs = '{10, 100, 40}; ys = '{0, 50, 120};
        load(0, xs, ys, 9);
        req_valid[0] = 1'b1;
        #1;
        k = 0;
        while (!req_ready[0] && k < 50) begin
            @(negedge clk);
            k++;
        end
        k = 0;
        do begin
            @(negedge clk);
            k++;
            req_valid = '0;
        end while (!ew_start && k < 40);
        check("abort_first_start", ew_start, 1);
        @(negedge clk);
        check("abort_in_wait", busy, 1);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("abort_busy", busy, 0);
        check("abort_start", ew_start, 0);
        check("abort_x1", ew_x1, 0);
        check("abort_x2", ew_x2, 0);
        check("abort_y1", ew_y1, 0);
        check("abort_y2", ew_y2, 0);
        check("abort_long", ew_long, 0);
        check("abort_cmp", cmp_valid, 0);
        check("abort_id", cmp_id, 0);
        check("abort_edges", cmp_edges, 0);
        check("abort_ready", 32'(req_ready), 0);
        ew_done = 1'b1;
        @(negedge clk);
        ew_done = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (cmp_valid || busy || ew_start) seen = 1'b1;
        end
        check("abort_quiet", seen, 0);
        xs = '{10, 100, 40}; ys = '{0, 50, 120};
        run_tri(0, xs, ys, 4, 3, 1'b0);

        // Randomized triangles, with ties forced often enough to hit 0 and 2 edges.
        for (int t = 0; t < 40; t++) begin
            for (int v = 0; v < 3; v++) begin
                xs[v] = $urandom_range(0, 319);
                if ($urandom_range(0, 2) == 0) ys[v] = 20 * $urandom_range(1, 2);
                else                           ys[v] = $urandom_range(0, 255);
            end
            run_tri($urandom_range(0, NUM_REQ - 1), xs, ys, $urandom_range(0, 15),
                    $urandom_range(1, 4), 1'b0);
        end

`ifdef SCAN_CLIP_EN
        xs = '{0, 50, 20}; ys = '{150, 250, 240};
        run_tri(1, xs, ys, 6, 3, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
